// File: rtl/ddr_cmd_arbiter.sv
// Read/write/refresh command arbiter enforcing turnaround spacing and write/read fairness.
// Periodic refresh is compiled in only when the macro DDR_ARB_REFRESH_EN is defined.
module ddr_cmd_arbiter #(
  parameter int unsigned TCCD     = 4,
  parameter int unsigned TWTR     = 6,
  parameter int unsigned TRTW     = 4,
  parameter int unsigned MAX_SAME = 4,
  parameter int unsigned TREFI    = 780,
  parameter int unsigned TRFC     = 35
) (
  input  logic        clock_t,
  input  logic        reset_n,
  input  logic        wr_req,
  input  logic [31:0] wr_addr,
  input  logic        rd_req,
  input  logic [31:0] rd_addr,
  output logic        cmd_valid,
  output logic [1:0]  cmd_type,
  output logic [31:0] cmd_addr,
  input  logic        cmd_ack,
  output logic        wr_gnt,
  output logic        rd_gnt,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP, REFRESH} state_t;

  localparam logic [1:0] T_NONE = 2'b00;
  localparam logic [1:0] T_WR   = 2'b01;
  localparam logic [1:0] T_RD   = 2'b10;
  localparam logic [1:0] T_REF  = 2'b11;

  state_t      state_q, state_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [1:0]  cmd_type_q, cmd_type_d;
  logic [31:0] cmd_addr_q, cmd_addr_d;
  logic [1:0]  last_type_q, last_type_d;
  logic [1:0]  dir_q, dir_d;
  logic [7:0]  same_cnt_q, same_cnt_d;
  logic [7:0]  elapsed_q, elapsed_d;
  logic        ack_s;
  logic        ref_pending_s;
  logic [1:0]  cand_s;
  logic [31:0] cand_addr_s;
  logic [31:0] gap_s;
  logic        eligible_s;

  assign ack_s = cmd_valid_q & cmd_ack;

`ifdef DDR_ARB_REFRESH_EN
  logic [15:0] ref_cnt_q, ref_cnt_d;
  logic        ref_pending_q, ref_pending_d;
  logic        ref_wrap_s;

  // Refresh interval timer; an expiry while one is already pending is absorbed.
  always_comb begin
    ref_wrap_s = (ref_cnt_q == 16'(TREFI - 32'd1));
    if (ref_wrap_s) begin
      ref_cnt_d     = 16'd0;
      ref_pending_d = 1'b1;
    end else if (ack_s && (cmd_type_q == T_REF)) begin
      ref_cnt_d     = ref_cnt_q + 16'd1;
      ref_pending_d = 1'b0;
    end else begin
      ref_cnt_d     = ref_cnt_q + 16'd1;
      ref_pending_d = ref_pending_q;
    end
  end

  // Refresh timer registers.
  always_ff @(posedge clock_t or negedge reset_n) begin
    if (!reset_n) begin
      ref_cnt_q     <= 16'd0;
      ref_pending_q <= 1'b0;
    end else begin
      ref_cnt_q     <= ref_cnt_d;
      ref_pending_q <= ref_pending_d;
    end
  end

  assign ref_pending_s = ref_pending_q;
`else
  logic unused_ref_s;
  assign unused_ref_s  = ^{1'b0, TREFI};
  assign ref_pending_s = 1'b0;
`endif

  // Highest-priority candidate and the spacing it needs after the last accepted command.
  always_comb begin
    cand_s = T_NONE;
    if (ref_pending_s) begin
      cand_s = T_REF;
    end else if (wr_req && rd_req) begin
      if (dir_q == T_NONE) begin
        cand_s = T_WR;
      end else if (32'(same_cnt_q) >= MAX_SAME) begin
        cand_s = ~dir_q;
      end else begin
        cand_s = dir_q;
      end
    end else if (wr_req) begin
      cand_s = T_WR;
    end else if (rd_req) begin
      cand_s = T_RD;
    end else begin
      cand_s = T_NONE;
    end

    case (cand_s)
      T_WR:    cand_addr_s = wr_addr;
      T_RD:    cand_addr_s = rd_addr;
      default: cand_addr_s = 32'd0;
    endcase

    if (last_type_q == T_NONE) begin
      gap_s = 32'd0;
    end else if ((cand_s == T_REF) || (last_type_q == T_REF) || (cand_s == last_type_q)) begin
      gap_s = TCCD;
    end else if (cand_s == T_RD) begin
      gap_s = TWTR;
    end else begin
      gap_s = TRTW;
    end

    // elapsed reads 0 in the cycle after the ack, and selection precedes cmd_valid by one cycle.
    eligible_s = (cand_s != T_NONE) && ((32'(elapsed_q) + 32'd2) >= gap_s);
  end

  // Next-state, command offer and grant bookkeeping.
  always_comb begin
    state_d     = state_q;
    cmd_valid_d = cmd_valid_q;
    cmd_type_d  = cmd_type_q;
    cmd_addr_d  = cmd_addr_q;
    last_type_d = last_type_q;
    dir_d       = dir_q;
    same_cnt_d  = same_cnt_q;
    if (ack_s) begin
      elapsed_d = 8'd0;
    end else if (elapsed_q == 8'd255) begin
      elapsed_d = elapsed_q;
    end else begin
      elapsed_d = elapsed_q + 8'd1;
    end

    case (state_q)
      IDLE, GAP: begin
        if (eligible_s) begin
          state_d     = ISSUE;
          cmd_valid_d = 1'b1;
          cmd_type_d  = cand_s;
          cmd_addr_d  = cand_addr_s;
        end else if ((state_q == GAP) && (cand_s == T_NONE) && (32'(elapsed_q) >= TWTR)) begin
          state_d = IDLE;
        end else begin
          state_d = state_q;
        end
      end
      ISSUE: begin
        if (ack_s) begin
          cmd_valid_d = 1'b0;
          cmd_type_d  = T_NONE;
          cmd_addr_d  = 32'd0;
          last_type_d = cmd_type_q;
          if (cmd_type_q == T_REF) begin
            state_d = REFRESH;
          end else begin
            state_d = GAP;
            if (cmd_type_q != dir_q) begin
              dir_d      = cmd_type_q;
              same_cnt_d = 8'd1;
            end else if (32'(same_cnt_q) < MAX_SAME) begin
              same_cnt_d = same_cnt_q + 8'd1;
            end else begin
              same_cnt_d = same_cnt_q;
            end
          end
        end else begin
          state_d = ISSUE;
        end
      end
      REFRESH: begin
        if ((32'(elapsed_q) + 32'd2) >= TRFC) begin
          state_d = IDLE;
        end else begin
          state_d = REFRESH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbiter state and registered command outputs.
  always_ff @(posedge clock_t or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cmd_valid_q <= 1'b0;
      cmd_type_q  <= T_NONE;
      cmd_addr_q  <= 32'd0;
      last_type_q <= T_NONE;
      dir_q       <= T_NONE;
      same_cnt_q  <= 8'd0;
      elapsed_q   <= 8'd255;
    end else begin
      state_q     <= state_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_type_q  <= cmd_type_d;
      cmd_addr_q  <= cmd_addr_d;
      last_type_q <= last_type_d;
      dir_q       <= dir_d;
      same_cnt_q  <= same_cnt_d;
      elapsed_q   <= elapsed_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_type  = cmd_type_q;
  assign cmd_addr  = cmd_addr_q;
  assign wr_gnt    = ack_s & (cmd_type_q == T_WR);
  assign rd_gnt    = ack_s & (cmd_type_q == T_RD);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ddr_cmd_arbiter.sv
// Bench for ddr_cmd_arbiter: vector table of chained requests checked by a scoreboard,
// plus sequences for fairness, reset during an offered command and (when enabled) refresh.
module tb_ddr_cmd_arbiter;

  typedef struct {
    logic [1:0]  typ;
    logic [31:0] addr;
    int          gap;
  } exp_t;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    int          idle;
    int          gap;
  } vec_t;

  logic        clock_t = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_req  = 1'b0;
  logic [31:0] wr_addr = 32'd0;
  logic        rd_req  = 1'b0;
  logic [31:0] rd_addr = 32'd0;
  logic        cmd_ack = 1'b0;
  logic        cmd_valid;
  logic [1:0]  cmd_type;
  logic [31:0] cmd_addr;
  logic        wr_gnt;
  logic        rd_gnt;
  logic        busy;

  exp_t sb_q[$];
  exp_t cur;
  int   n_checks     = 0;
  int   n_errors     = 0;
  int   cyc          = 0;
  int   last_ack_cyc = 0;
  bit   ack_en       = 1'b1;
  bit   sb_en        = 1'b1;
  bit   seen         = 1'b0;
  logic prev_valid   = 1'b0;

  ddr_cmd_arbiter dut (
    .clock_t  (clock_t),
    .reset_n  (reset_n),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .cmd_valid(cmd_valid),
    .cmd_type (cmd_type),
    .cmd_addr (cmd_addr),
    .cmd_ack  (cmd_ack),
    .wr_gnt   (wr_gnt),
    .rd_gnt   (rd_gnt),
    .busy     (busy)
  );

  always #5 clock_t = ~clock_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_gnt(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock_t);
      if (wr_gnt || rd_gnt) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: no grant within 100 cycles", name);
    end
  endtask

  task automatic wait_valid(input string name, input int limit);
    bit got;
    got = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock_t);
      if (cmd_valid) begin
        got = 1'b1;
        break;
      end
    end
    chk(name, 32'(got), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clock_t);
    reset_n = 1'b0;
    wr_req  = 1'b0;
    rd_req  = 1'b0;
    repeat (2) @(negedge clock_t);
    reset_n = 1'b1;
  endtask

  initial begin : cycle_counter
    forever begin
      @(posedge clock_t);
      cyc++;
    end
  end

  // Controller model: acknowledges each offered command one cycle after cmd_valid rises.
  initial begin : responder
    forever begin
      @(posedge clock_t);
      #1;
      if (cmd_ack) begin
        cmd_ack = 1'b0;
        seen    = 1'b0;
      end else if (cmd_valid && ack_en) begin
        if (seen) cmd_ack = 1'b1;
        else      seen    = 1'b1;
      end else begin
        seen = 1'b0;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clock_t);
      if (cmd_valid && !prev_valid && sb_en) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_unexpected: got type %0b addr 0x%0h, expected no command", cmd_type, cmd_addr);
        end else begin
          cur = sb_q.pop_front();
          chk("rise_type", 32'(cmd_type), 32'(cur.typ));
          chk("rise_addr", cmd_addr, cur.addr);
          if (cur.gap >= 0) chk("rise_gap", 32'(cyc - last_ack_cyc), 32'(cur.gap));
        end
      end
      if (cmd_valid && cmd_ack) begin
        last_ack_cyc = cyc;
        if (sb_en) begin
          chk("ack_type", 32'(cmd_type), 32'(cur.typ));
          chk("ack_addr", cmd_addr, cur.addr);
          chk("wr_gnt", 32'(wr_gnt), 32'(cur.typ == 2'b01));
          chk("rd_gnt", 32'(rd_gnt), 32'(cur.typ == 2'b10));
        end
      end else begin
        chk("gnt_idle", 32'({wr_gnt, rd_gnt}), 32'd0);
      end
      prev_valid = cmd_valid;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    vec_t vt[8];
    bit   ok;
    int   wcnt;
    int   rcnt;
    int   rel;

    vt[0] = '{1'b1, 32'h0000_0100, 0, -1};
    vt[1] = '{1'b0, 32'h0000_0200, 10, -1};
    vt[2] = '{1'b0, 32'h0000_0204, 0, 4};
    vt[3] = '{1'b1, 32'h0000_0300, 0, 4};
    vt[4] = '{1'b1, 32'h0000_0304, 0, 4};
    vt[5] = '{1'b0, 32'h0000_0208, 0, 6};
    vt[6] = '{1'b1, 32'h0000_030C, 0, 4};
    vt[7] = '{1'b1, 32'h0000_0310, 9, -1};

    @(negedge clock_t);
    chk("rst_valid", 32'(cmd_valid), 32'd0);
    chk("rst_type", 32'(cmd_type), 32'd0);
    chk("rst_addr", cmd_addr, 32'd0);
    chk("rst_gnt", 32'({wr_gnt, rd_gnt}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clock_t);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      repeat (vt[i].idle) @(negedge clock_t);
      if (vt[i].idle >= 8) chk("busy_idle", 32'(busy), 32'd0);
      sb_q.push_back('{vt[i].is_wr ? 2'b01 : 2'b10, vt[i].addr, vt[i].gap});
      if (vt[i].is_wr) begin
        wr_addr = vt[i].addr;
        wr_req  = 1'b1;
      end else begin
        rd_addr = vt[i].addr;
        rd_req  = 1'b1;
      end
      wait_gnt($sformatf("vec%0d", i), ok);
      wr_req = 1'b0;
      rd_req = 1'b0;
    end

    // Both directions requesting from fresh reset: write first, four writes, one read, writes again.
    do_reset();
    sb_q.push_back('{2'b01, 32'h0000_1000, -1});
    for (int i = 0; i < 3; i++) sb_q.push_back('{2'b01, 32'h0000_1000, 4});
    sb_q.push_back('{2'b10, 32'h0000_2000, 6});
    for (int i = 0; i < 2; i++) sb_q.push_back('{2'b01, 32'h0000_1000, 4});
    wr_addr = 32'h0000_1000;
    rd_addr = 32'h0000_2000;
    wr_req  = 1'b1;
    rd_req  = 1'b1;
    wcnt    = 0;
    rcnt    = 0;
    while (wcnt < 6) begin
      wait_gnt("starve", ok);
      if (!ok) break;
      if (rd_gnt) begin
        rcnt++;
        rd_req = 1'b0;
        chk("starve_rd_pos", 32'(wcnt), 32'd4);
      end
      if (wr_gnt) wcnt++;
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    chk("starve_rd_cnt", 32'(rcnt), 32'd1);

    // Reset while a read is being offered, then the same read again with no spacing.
    repeat (10) @(negedge clock_t);
    ack_en = 1'b0;
    sb_q.push_back('{2'b10, 32'h0000_3000, -1});
    rd_addr = 32'h0000_3000;
    rd_req  = 1'b1;
    wait_valid("rst_offer_seen", 20);
    reset_n = 1'b0;
    #1;
    chk("async_valid", 32'(cmd_valid), 32'd0);
    chk("async_type", 32'(cmd_type), 32'd0);
    chk("async_addr", cmd_addr, 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    ack_en = 1'b1;
    sb_q.push_back('{2'b10, 32'h0000_3000, -1});
    repeat (2) @(negedge clock_t);
    reset_n = 1'b1;
    rel = cyc;
    wait_valid("rst_reissue_seen", 20);
    chk("rst_no_gap", 32'(cyc - rel), 32'd1);
    wait_gnt("rst_reissue", ok);
    rd_req = 1'b0;
    repeat (10) @(negedge clock_t);

`ifdef DDR_ARB_REFRESH_EN
    // Continuous writes across the first refresh expiry.
    do_reset();
    rel     = cyc;
    sb_en   = 1'b0;
    wr_addr = 32'h0000_4000;
    wr_req  = 1'b1;
    ok      = 1'b0;
    for (int i = 0; i < 900; i++) begin
      @(negedge clock_t);
      if (cmd_valid && (cmd_type == 2'b11)) begin
        ok = 1'b1;
        break;
      end
    end
    chk("ref_seen", 32'(ok), 32'd1);
    chk("ref_rise_min", 32'((cyc - rel) >= 781), 32'd1);
    chk("ref_rise_max", 32'((cyc - rel) <= 786), 32'd1);
    chk("ref_addr", cmd_addr, 32'd0);
    ok = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (cmd_valid && cmd_ack) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock_t);
    end
    chk("ref_ack", 32'(ok), 32'd1);
    rcnt = 0;
    for (int i = 0; i < 35; i++) begin
      @(negedge clock_t);
      if (cmd_valid) rcnt++;
    end
    chk("ref_quiet", 32'(rcnt), 32'd0);
    wait_gnt("ref_resume", ok);
    wr_req = 1'b0;
    repeat (10) @(negedge clock_t);
    sb_en = 1'b1;
`endif

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ddr_cmd_arbiter.md
DDR_CMD_ARBITER -- requirements
Module: ddr_cmd_arbiter

Interface
REQ-001 Parameter TCCD, default 4: minimum cycles between accepted commands in the same direction.
REQ-002 Parameter TWTR, default 6: minimum cycles from an accepted write to the next read; must be >= TCCD.
REQ-003 Parameter TRTW, default 4: minimum cycles from an accepted read to the next write; must be >= TCCD.
REQ-004 Parameter MAX_SAME, default 4: maximum consecutive same-direction grants while the other direction waits.
REQ-005 Parameter TREFI, default 780: refresh interval in cycles.
REQ-006 Parameter TRFC, default 35: refresh busy time in cycles.
REQ-007 clock_t  in  1  sole clock, rising edge.
REQ-008 reset_n  in  1  asynchronous, active-low reset.
REQ-009 wr_req  in  1  write request, held until wr_gnt.
REQ-010 wr_addr  in  32  write address, stable while wr_req is high.
REQ-011 rd_req  in  1  read request, held until rd_gnt.
REQ-012 rd_addr  in  32  read address, stable while rd_req is high.
REQ-013 cmd_valid  out  1  command offered to the controller.
REQ-014 cmd_type  out  2  01 write, 10 read, 11 refresh; 00 when idle.
REQ-015 cmd_addr  out  32  address of the offered command; 0 for refresh.
REQ-016 cmd_ack  in  1  controller accepts the offered command.
REQ-017 wr_gnt, rd_gnt  out  1 each  single-cycle pulse, asserted in the cmd_ack cycle of the matching command.
REQ-018 busy  out  1  high in ISSUE, GAP or REFRESH.

Function
REQ-019 The FSM SHALL have the states IDLE, ISSUE, GAP and REFRESH.
REQ-020 IDLE->ISSUE when an eligible candidate exists; cmd_valid, cmd_type and cmd_addr are registered and assert on the cycle after selection.
REQ-021 ISSUE: outputs hold unchanged until cmd_ack; on cmd_ack, read/write -> GAP and refresh -> REFRESH.
REQ-022 Elapsed counter: cleared on cmd_ack, incremented each cycle afterwards, saturating at 255.
REQ-023 Eligibility gap G (cycles after the last ack): same direction TCCD; write->read TWTR; read->write TRTW; refresh TCCD; no gap before the first command after reset.
REQ-024 If a candidate is pending, the next cmd_valid SHALL rise exactly at ack_cycle+G, and never earlier.
REQ-025 Priority: refresh pending > same direction as last > opposite direction.
REQ-026 Anti-starvation: same_cnt counts consecutive same-direction grants; when same_cnt==MAX_SAME and the opposite request is pending, the opposite direction wins; same_cnt resets to 1 on a direction change.
REQ-027 GAP->IDLE when no request is pending and elapsed >= TWTR.
REQ-028 REFRESH holds cmd_valid low for TRFC cycles after the refresh ack, then returns to IDLE.
REQ-029 A request that drops before its grant is a protocol violation; the command already offered SHALL remain until cmd_ack.
REQ-030 wr_req and rd_req asserted together from IDLE with no history: the write wins.

Reset
REQ-031 While reset_n is low, the block SHALL clear immediately, without waiting for a clock edge: cmd_valid=0, cmd_type=00, cmd_addr=0, wr_gnt=0, rd_gnt=0, busy=0, state=IDLE, same_cnt=0, elapsed=255, refresh counter=0, ref_pending=0.
REQ-032 Reset asserted during ISSUE or REFRESH SHALL abandon the command; after release the block behaves as freshly reset.

Configuration
REQ-033 Macro DDR_ARB_REFRESH_EN defined: the refresh timer counts 0..TREFI-1; on wrap it sets ref_pending, cleared on the refresh ack; a further expiry while pending does not queue a second refresh.
REQ-034 Macro DDR_ARB_REFRESH_EN undefined: there is no timer, cmd_type 11 is never produced, the REFRESH state is unreachable, and TREFI/TRFC are ignored.

Verification
REQ-035 Single write, addr 0x100, with cmd_ack returned 1 cycle after cmd_valid -> cmd_type 01, cmd_addr 0x100, wr_gnt pulses once, busy then falls.
REQ-036 Two back-to-back reads acked at cycle 10 -> second cmd_valid rises at cycle 14, not before.
REQ-037 Write acked at cycle 20 with a read pending -> read cmd_valid rises at cycle 26; read acked at 30 with a write pending -> write cmd_valid rises at 34.
REQ-038 wr_req held continuously with rd_req also high -> exactly 4 write grants, then 1 read grant, then writes resume.
REQ-039 With DDR_ARB_REFRESH_EN defined and wr_req held continuously -> a refresh (type 11) is issued within TCCD cycles after each 780-cycle expiry, and no cmd_valid occurs for 35 cycles after its ack.
REQ-040 reset_n dropped while cmd_valid is high -> cmd_valid goes low the same cycle; after release, a pending read is issued with no gap.
